// File: rtl/pi_link_rx.sv
// pi_link_rx: receiver for the Raspberry Pi parallel link.
// Synchronises the Pi request strobe, runs a 4-phase req/ack handshake,
// packs captured bytes little-endian into words and buffers them in a
// first-word-fall-through FIFO drained by a valid/ready stream.
module pi_link_rx #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WORD_BYTES  = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned TIMEOUT     = 1000000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               pi_hsk_raw,
  input  logic [DATA_W-1:0]                  data,
  output logic                               fpga_hsk,
  input  logic                               flush,
  output logic [DATA_W*WORD_BYTES-1:0]       out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               tmo_err
);

  localparam int unsigned WORD_W   = DATA_W * WORD_BYTES;
  localparam int unsigned LVL_W    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned IDX_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int unsigned LAST_IDX = WORD_BYTES - 1;
  localparam int unsigned TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam bit          TMO_EN   = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACK     = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [DATA_W-1:0]      r_data_q;
  logic                   r_fpga_hsk;
  logic                   r_tmo_err;
  logic [TMO_W-1:0]       r_tmo_cnt;
  logic [IDX_W-1:0]       r_byte_idx;
  logic [WORD_W-1:0]      r_word;
  logic                   r_push_pend;
  logic [WORD_W-1:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [LVL_W-1:0]       r_level;
  logic [LVL_W-1:0]       w_level_nxt;
  logic                   r_full;
  logic                   r_out_valid;

  logic w_pi_hsk;
  logic w_last_lane;
  logic w_stall;
  logic w_tmo_hit;
  logic w_capture;
  logic w_tmo_set;
  logic w_hsk_nxt;
  logic w_push;
  logic w_pop;

  assign w_pi_hsk    = r_sync[SYNC_STAGES-1];
  assign w_last_lane = (r_byte_idx == IDX_W'(LAST_IDX));
  // Only the word-completing capture waits for FIFO space.
  assign w_stall     = r_full && w_last_lane;
  assign w_tmo_hit   = TMO_EN && (r_tmo_cnt == TMO_W'(TMO_LAST));
  assign w_push      = r_push_pend && !flush;
  assign w_pop       = r_out_valid && out_ready && !flush;

  assign fpga_hsk   = r_fpga_hsk;
  assign tmo_err    = r_tmo_err;
  assign out_valid  = r_out_valid;
  assign fifo_level = r_level;
  assign out_data   = r_mem[r_rd_ptr];

  // Strobe synchroniser chain.
  always_ff @(posedge clk) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], pi_hsk_raw};
  end

  // Data bus sampled every cycle; only read once the strobe is synchronised.
  always_ff @(posedge clk) begin
    r_data_q <= data;
  end

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Handshake next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_pi_hsk && !w_stall) w_state_nxt = S_ACK;
      S_ACK:     if (!w_pi_hsk)            w_state_nxt = S_IDLE;
                 else if (w_tmo_hit)       w_state_nxt = S_RECOVER;
      S_RECOVER: if (!w_pi_hsk)            w_state_nxt = S_IDLE;
      default:                             w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the transition.
  always_comb begin
    w_capture = (r_state == S_IDLE) && (w_state_nxt == S_ACK) && !flush;
    w_tmo_set = (r_state == S_ACK) && (w_state_nxt == S_RECOVER);
    w_hsk_nxt = (w_state_nxt == S_ACK);
  end

  // Registered acknowledge, sticky timeout flag and ACK dwell counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fpga_hsk <= 1'b0;
      r_tmo_err  <= 1'b0;
      r_tmo_cnt  <= '0;
    end else begin
      r_fpga_hsk <= w_hsk_nxt;
      if (w_tmo_set) r_tmo_err <= 1'b1;
      if (r_state != S_ACK) r_tmo_cnt <= '0;
      else                  r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  // Lane index and one-cycle-delayed push of a completed word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_idx  <= '0;
      r_push_pend <= 1'b0;
    end else begin
      r_push_pend <= 1'b0;
      if (flush) begin
        r_byte_idx <= '0;
      end else if (w_capture) begin
        if (w_last_lane) begin
          r_byte_idx  <= '0;
          r_push_pend <= 1'b1;
        end else begin
          r_byte_idx <= r_byte_idx + IDX_W'(1);
        end
      end
    end
  end

  // Word assembly register.
  always_ff @(posedge clk) begin
    if (w_capture) r_word[r_byte_idx*DATA_W +: DATA_W] <= r_data_q;
  end

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)      w_level_nxt = r_level + LVL_W'(1);
    else if (!w_push && w_pop) w_level_nxt = r_level - LVL_W'(1);
  end

  // FIFO pointers and registered status flags.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_full      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level     <= w_level_nxt;
      r_full      <= (w_level_nxt == LVL_W'(FIFO_DEPTH));
      r_out_valid <= (w_level_nxt != '0);
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_word;
  end

endmodule

// File: tb/tb_pi_link_rx.sv
// Self-checking bench for pi_link_rx: directed handshake, packing, stall,
// flush, timeout and reset scenarios with random payloads, checked against
// a queue-based model of the words the Pi has delivered.
module tb_pi_link_rx;

  localparam int unsigned DW  = 8;
  localparam int unsigned WB  = 2;
  localparam int unsigned SS  = 2;
  localparam int unsigned FD  = 4;
  localparam int unsigned TMO = 20;

  logic                       clk;
  logic                       reset;
  logic                       pi_hsk_raw;
  logic [DW-1:0]              data;
  logic                       fpga_hsk;
  logic                       flush;
  logic [DW*WB-1:0]           out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [$clog2(FD+1)-1:0]    fifo_level;
  logic                       tmo_err;

  int checks   = 0;
  int failures = 0;

  logic [DW*WB-1:0] exp_q[$];
  logic [DW-1:0]    part_q[$];

  pi_link_rx #(
    .DATA_W(DW), .WORD_BYTES(WB), .SYNC_STAGES(SS), .FIFO_DEPTH(FD), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .pi_hsk_raw(pi_hsk_raw), .data(data),
    .fpga_hsk(fpga_hsk), .flush(flush), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .fifo_level(fifo_level),
    .tmo_err(tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Model: bytes accumulate little-endian; a full set becomes one word.
  task automatic model_capture(input logic [DW-1:0] b);
    logic [DW*WB-1:0] w;
    part_q.push_back(b);
    if (part_q.size() == WB) begin
      w = '0;
      for (int k = 0; k < WB; k++) w[k*DW +: DW] = part_q[k];
      exp_q.push_back(w);
      part_q.delete();
    end
  endtask

  task automatic check_fifo(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
    chk({tag, "_level"}, 32'(fifo_level), 32'(exp_q.size()));
    if (exp_q.size() != 0) chk({tag, "_data"}, 32'(out_data), 32'(exp_q[0]));
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    do begin tick(); n++; end while (fpga_hsk !== 1'b1 && n < 100);
  endtask

  task automatic wait_fall(output int n);
    n = 0;
    do begin tick(); n++; end while (fpga_hsk !== 1'b0 && n < 100);
  endtask

  // One full Pi transfer; optionally pop the head on the push cycle.
  task automatic send_byte(input logic [DW-1:0] b, input bit pop_on_push);
    int  n;
    bit  pushing;
    data = b;
    tick();
    pi_hsk_raw = 1'b1;
    wait_rise(n);
    chk("ack_rise_lat", 32'(n), 32'(SS + 1));
    chk("level_at_cap", 32'(fifo_level), 32'(exp_q.size()));
    pushing = (part_q.size() == WB - 1);
    if (pushing && pop_on_push) out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (pushing && pop_on_push) void'(exp_q.pop_front());
    model_capture(b);
    check_fifo("after_cap");
    pi_hsk_raw = 1'b0;
    wait_fall(n);
    chk("ack_fall_lat", 32'(n), 32'(SS + 1));
    data = DW'($urandom);
  endtask

  task automatic pop_one();
    check_fifo("pre_pop");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    void'(exp_q.pop_front());
    check_fifo("post_pop");
  endtask

  initial begin
    int n;
    logic [DW-1:0] b;
    reset = 1'b1; pi_hsk_raw = 1'b0; data = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_hsk",   32'(fpga_hsk),   32'(0));
    chk("rst_valid", 32'(out_valid),  32'(0));
    chk("rst_level", 32'(fifo_level), 32'(0));
    chk("rst_tmo",   32'(tmo_err),    32'(0));
    tick();

    // Packing: fixed pair then random bytes, no draining.
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    chk("pack_2211", 32'(out_data), 32'h2211);
    repeat (4) send_byte(DW'($urandom), 1'b0);

    // Simultaneous push and pop keeps the level constant.
    send_byte(DW'($urandom), 1'b0);
    send_byte(DW'($urandom), 1'b1);
    chk("pushpop_level", 32'(fifo_level), 32'(3));

    // Fill the FIFO, then a lane-0 capture still proceeds.
    send_byte(DW'($urandom), 1'b0);
    send_byte(DW'($urandom), 1'b0);
    chk("full_level", 32'(fifo_level), 32'(FD));
    send_byte(DW'($urandom), 1'b0);

    // Word-completing request is stalled while full.
    b = DW'($urandom);
    data = b;
    tick();
    pi_hsk_raw = 1'b1;
    repeat (10) tick();
    chk("stall_no_ack", 32'(fpga_hsk), 32'(0));
    chk("stall_level",  32'(fifo_level), 32'(FD));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    void'(exp_q.pop_front());
    chk("stall_pop_level", 32'(fifo_level), 32'(FD - 1));
    n = 0;
    while (fpga_hsk !== 1'b1 && n < 10) begin tick(); n++; end
    chk("stall_release", 32'(n >= 1 && n <= 2), 32'(1));
    tick();
    model_capture(b);
    check_fifo("stall_push");
    pi_hsk_raw = 1'b0;
    wait_fall(n);
    chk("stall_fall", 32'(n), 32'(SS + 1));

    pop_one();
    pop_one();

    // Flush mid-word discards queued words and the partial byte.
    send_byte(8'hAA, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    part_q.delete();
    check_fifo("flush");
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    chk("flush_word", 32'(out_data), 32'hCCBB);
    chk("flush_level", 32'(fifo_level), 32'(1));

    // Flush on the capture edge drops that byte but the ACK still happens.
    data = DW'($urandom);
    tick();
    pi_hsk_raw = 1'b1;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    chk("flushcap_hsk", 32'(fpga_hsk), 32'(1));
    check_fifo("flushcap");
    pi_hsk_raw = 1'b0;
    wait_fall(n);
    send_byte(DW'($urandom), 1'b0);
    send_byte(DW'($urandom), 1'b0);

    // Timeout: strobe held high past the ACK limit.
    b = DW'($urandom);
    data = b;
    tick();
    pi_hsk_raw = 1'b1;
    wait_rise(n);
    chk("tmo_rise", 32'(n), 32'(SS + 1));
    chk("tmo_pre_err", 32'(tmo_err), 32'(0));
    model_capture(b);
    wait_fall(n);
    chk("tmo_lat", 32'(n), 32'(TMO));
    chk("tmo_err_set", 32'(tmo_err), 32'(1));
    repeat (10) tick();
    chk("tmo_recover_hsk", 32'(fpga_hsk), 32'(0));
    check_fifo("tmo_recover");
    pi_hsk_raw = 1'b0;
    repeat (5) tick();
    chk("tmo_idle_hsk", 32'(fpga_hsk), 32'(0));
    send_byte(DW'($urandom), 1'b0);
    chk("tmo_sticky", 32'(tmo_err), 32'(1));

    // Random traffic with random draining.
    for (int i = 0; i < 16; i++) begin
      if (part_q.size() == WB - 1 && exp_q.size() == FD) pop_one();
      send_byte(DW'($urandom), 1'b0);
      if ($urandom_range(0, 2) == 0 && exp_q.size() != 0) pop_one();
    end

    // Reset while ACK is high, with the request still held afterwards.
    b = DW'($urandom);
    data = b;
    tick();
    pi_hsk_raw = 1'b1;
    wait_rise(n);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    part_q.delete();
    chk("rst2_hsk",   32'(fpga_hsk),   32'(0));
    chk("rst2_level", 32'(fifo_level), 32'(0));
    chk("rst2_tmo",   32'(tmo_err),    32'(0));
    chk("rst2_valid", 32'(out_valid),  32'(0));
    wait_rise(n);
    chk("rst2_rise", 32'(n), 32'(SS + 1));
    model_capture(b);
    pi_hsk_raw = 1'b0;
    wait_fall(n);
    send_byte(DW'($urandom), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
